// File: rtl/mem_port_arbiter.sv
// Two-port arbiter in front of a single-ported unified memory.
// Fetch (i_*) and load/store (d_*) requesters use a req/ack handshake. Data wins
// arbitration unless fetch has been waiting MAX_WAIT or more edges. Each access
// holds mem_req for MEM_LAT cycles, then acks the owner for one cycle.
// Optional feature: define ARB_PERF_CNT_EN to build the two performance counters;
// otherwise perf_fetch_stall and perf_data_grants are tied to zero.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned MEM_LAT  = 1,
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_ack,
  output logic [31:0]       i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [31:0]       d_wdata,
  input  logic [3:0]        d_wstrb,
  output logic              d_ack,
  output logic [31:0]       d_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_wstrb,
  input  logic [31:0]       mem_rdata,
  output logic [31:0]       perf_fetch_stall,
  output logic [31:0]       perf_data_grants
);

  localparam int unsigned LatW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam int unsigned StW  = $clog2(MAX_WAIT + 1);
  localparam logic [LatW-1:0] LatInit  = LatW'(MEM_LAT - 1);
  localparam logic [StW-1:0]  MaxWaitC = StW'(MAX_WAIT);

  typedef enum logic [1:0] {StIdle, StAccess, StAck} state_e;

  state_e            r_state;
  state_e            w_state_next;
  logic [LatW-1:0]   r_lat_cnt;
  logic              r_own_fetch;
  logic [StW-1:0]    r_starve;
  logic              r_mem_req;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [31:0]       r_mem_wdata;
  logic [3:0]        r_mem_wstrb;
  logic [31:0]       r_i_rdata;
  logic [31:0]       r_d_rdata;

  logic w_grant_f;
  logic w_grant_d;
  logic w_done;
  logic w_fetch_busy;

  // Arbitration happens only in IDLE; fetch overrides data once it has starved.
  assign w_grant_f    = (r_state == StIdle) && i_req && (!d_req || (r_starve >= MaxWaitC));
  assign w_grant_d    = (r_state == StIdle) && !w_grant_f && d_req;
  assign w_done       = (r_state == StAccess) && (r_lat_cnt == '0);
  assign w_fetch_busy = (r_state != StIdle) && r_own_fetch;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= StIdle;
    else      r_state <= w_state_next;
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:   if (w_grant_f || w_grant_d) w_state_next = StAccess;
      StAccess: if (w_done) w_state_next = StAck;
      StAck:    w_state_next = StIdle;
      default:  w_state_next = StIdle;
    endcase
  end

  // Output decode: the owner's ack is high for the whole ACK cycle
  always_comb begin
    i_ack = (r_state == StAck) && r_own_fetch;
    d_ack = (r_state == StAck) && !r_own_fetch;
  end

  // Access datapath: latch the winner's request, count latency, capture read data
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_lat_cnt   <= '0;
      r_own_fetch <= 1'b0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_wstrb <= '0;
      r_i_rdata   <= '0;
      r_d_rdata   <= '0;
    end else if (w_grant_f || w_grant_d) begin
      r_own_fetch <= w_grant_f;
      r_mem_req   <= 1'b1;
      r_mem_we    <= w_grant_d && d_we;
      r_mem_addr  <= w_grant_f ? i_addr : d_addr;
      r_mem_wdata <= w_grant_f ? 32'h0 : d_wdata;
      r_mem_wstrb <= (w_grant_d && d_we) ? d_wstrb : 4'b0000;
      r_lat_cnt   <= LatInit;
    end else if (w_done) begin
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_wstrb <= 4'b0000;
      if (r_own_fetch)    r_i_rdata <= mem_rdata;
      else if (!r_mem_we) r_d_rdata <= mem_rdata;
    end else if (r_state == StAccess) begin
      r_lat_cnt <= r_lat_cnt - 1'b1;
    end
  end

  // Starvation counter: edges fetch waits while someone else owns or could win the port
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_starve <= '0;
    end else if (w_grant_f) begin
      r_starve <= '0;
    end else if (i_req && !w_fetch_busy && (r_starve != MaxWaitC)) begin
      r_starve <= r_starve + 1'b1;
    end
  end

  assign mem_req   = r_mem_req;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign mem_wstrb = r_mem_wstrb;
  assign i_rdata   = r_i_rdata;
  assign d_rdata   = r_d_rdata;

`ifdef ARB_PERF_CNT_EN
  logic [31:0] r_perf_stall;
  logic [31:0] r_perf_grants;

  // Performance counters, free-running and wrapping
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_perf_stall  <= '0;
      r_perf_grants <= '0;
    end else begin
      if (i_req && !w_fetch_busy) r_perf_stall <= r_perf_stall + 32'd1;
      if (w_grant_d)              r_perf_grants <= r_perf_grants + 32'd1;
    end
  end

  assign perf_fetch_stall = r_perf_stall;
  assign perf_data_grants = r_perf_grants;
`else
  assign perf_fetch_stall = 32'h0;
  assign perf_data_grants = 32'h0;
`endif

endmodule
